// File: rtl/seg7_scan_driver.sv
// ============================================================================
// Module  : seg7_scan_driver
// Brief   : Time-multiplexed, double-buffered hex 7-segment scan driver.
//           Optional blink support is enabled with `define SEG7_SCAN_BLINK_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_scan_driver #(
  parameter int NUM_DIGITS = 6,
  parameter int SCAN_DIV = 50000,
`ifdef SEG7_SCAN_BLINK_EN
  parameter int BLINK_FRAMES = 64,
`endif
  parameter int DIV_W = $clog2(SCAN_DIV + 1),
  parameter int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
`ifdef SEG7_SCAN_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
  input  logic                    lz_blank,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    frame_done
);

  localparam logic [DIV_W-1:0] c_div_last = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(NUM_DIGITS - 1);

  logic [DIV_W-1:0]        r_div;
  logic [4*NUM_DIGITS-1:0] r_pend_val;
  logic [NUM_DIGITS-1:0]   r_pend_mask;
  logic                    r_pend_valid;
  logic [4*NUM_DIGITS-1:0] r_act_val;
  logic [NUM_DIGITS-1:0]   r_act_mask;

  logic                    w_tick;
  logic                    w_wrap;
  logic [3:0]              w_nib;
  logic [NUM_DIGITS-1:0]   w_lz;
  logic [NUM_DIGITS-1:0]   w_dark_vec;
  logic                    w_dark;
  logic [NUM_DIGITS-1:0]   w_an_on;

  function automatic logic [6:0] f_decode(input logic [3:0] n);
    case (n)
      4'h0: f_decode = 7'h40;
      4'h1: f_decode = 7'h79;
      4'h2: f_decode = 7'h24;
      4'h3: f_decode = 7'h30;
      4'h4: f_decode = 7'h19;
      4'h5: f_decode = 7'h12;
      4'h6: f_decode = 7'h02;
      4'h7: f_decode = 7'h78;
      4'h8: f_decode = 7'h00;
      4'h9: f_decode = 7'h10;
      4'hA: f_decode = 7'h08;
      4'hB: f_decode = 7'h03;
      4'hC: f_decode = 7'h46;
      4'hD: f_decode = 7'h21;
      4'hE: f_decode = 7'h06;
      default: f_decode = 7'h0E;
    endcase
  endfunction

  assign w_tick = en && (r_div == c_div_last);
  assign w_wrap = w_tick && (digit_idx == c_idx_last);

`ifdef SEG7_SCAN_BLINK_EN
  localparam int BC_W = $clog2(BLINK_FRAMES + 1);
  localparam logic [BC_W-1:0] c_blink_last = BC_W'(BLINK_FRAMES - 1);

  logic [BC_W-1:0]       r_blink_cnt;
  logic                  r_blink_phase;
  logic [NUM_DIGITS-1:0] r_pend_blink;
  logic [NUM_DIGITS-1:0] r_act_blink;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_pend_blink  <= '0;
      r_act_blink   <= '0;
    end else begin
      if (w_wrap) begin
        if (r_blink_cnt == c_blink_last) begin
          r_blink_cnt   <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_blink_cnt <= r_blink_cnt + 1'b1;
        end
      end
      if (load && w_wrap) begin
        r_act_blink <= blink_mask;
      end else if (load) begin
        r_pend_blink <= blink_mask;
      end else if (w_wrap && r_pend_valid) begin
        r_act_blink <= r_pend_blink;
      end
    end
  end

  assign w_dark_vec = r_act_mask | ({NUM_DIGITS{lz_blank}} & w_lz) |
                      ({NUM_DIGITS{r_blink_phase}} & r_act_blink);
`else
  assign w_dark_vec = r_act_mask | ({NUM_DIGITS{lz_blank}} & w_lz);
`endif

  // A digit above 0 is a leading zero when it and every digit above it are 0.
  always_comb begin
    logic allz;
    allz   = 1'b1;
    w_lz   = '0;
    w_nib  = 4'h0;
    w_dark = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      allz = allz & (r_act_val[4*i +: 4] == 4'h0);
      if (i > 0) w_lz[i] = allz;
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_idx == IDX_W'(i)) begin
        w_nib  = r_act_val[4*i +: 4];
        w_dark = w_dark_vec[i];
      end
    end
  end

  assign w_an_on = ~(NUM_DIGITS'(1) << digit_idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div        <= '0;
      digit_idx    <= '0;
      r_pend_val   <= '0;
      r_pend_mask  <= '0;
      r_pend_valid <= 1'b0;
      r_act_val    <= '0;
      r_act_mask   <= '0;
      seg          <= 7'h7F;
      an           <= '1;
      frame_done   <= 1'b0;
    end else begin
      if (en) begin
        if (w_tick) begin
          r_div     <= '0;
          digit_idx <= (digit_idx == c_idx_last) ? '0 : digit_idx + 1'b1;
        end else begin
          r_div <= r_div + 1'b1;
        end
      end

      // A load landing on the wrap tick bypasses pending and shows next frame.
      if (load && w_wrap) begin
        r_act_val    <= value;
        r_act_mask   <= blank_mask;
        r_pend_valid <= 1'b0;
      end else if (load) begin
        r_pend_val   <= value;
        r_pend_mask  <= blank_mask;
        r_pend_valid <= 1'b1;
      end else if (w_wrap && r_pend_valid) begin
        r_act_val    <= r_pend_val;
        r_act_mask   <= r_pend_mask;
        r_pend_valid <= 1'b0;
      end

      frame_done <= w_wrap;
      if (!en) begin
        seg <= 7'h7F;
        an  <= '1;
      end else begin
        seg <= w_dark ? 7'h7F : f_decode(w_nib);
        an  <= w_dark ? '1 : w_an_on;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
// ============================================================================
// Module  : tb_seg7_scan_driver
// Brief   : Randomized self-checking bench for seg7_scan_driver against a
//           cycle-count based reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg7_scan_driver;

  localparam int ND = 6;
  localparam int SD = 4;
  localparam int FRAME = ND * SD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic        lz_blank = 1'b0;
  logic [23:0] value = '0;
  logic [5:0]  blank_mask = '0;
  logic [6:0]  seg;
  logic [5:0]  an;
  logic [2:0]  digit_idx;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  // Reference model: scan position derived from the count of enabled cycles.
  int          m_ecnt;
  logic [23:0] m_act_val, m_pend_val;
  logic [5:0]  m_act_mask, m_pend_mask;
  bit          m_pv;
  logic [6:0]  m_seg;
  logic [5:0]  m_an;
  bit          m_fd;
  logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg7_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load       (load),
    .value      (value),
    .blank_mask (blank_mask),
    .lz_blank   (lz_blank),
    .seg        (seg),
    .an         (an),
    .digit_idx  (digit_idx),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ecnt = 0;
    m_act_val = '0; m_pend_val = '0;
    m_act_mask = '0; m_pend_mask = '0;
    m_pv = 0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_an", 32'(an), 32'h3F);
    chk("rst_idx", 32'(digit_idx), 32'h0);
    chk("rst_fd", 32'(frame_done), 32'h0);
  endtask

  task automatic step(input bit e, input bit l, input bit lz,
                      input logic [23:0] v, input logic [5:0] bm);
    int d;
    bit wrap, dark;
    logic [23:0] upper;
    @(negedge clk);
    en = e; load = l; lz_blank = lz; value = v; blank_mask = bm;
    d = (m_ecnt / SD) % ND;
    wrap = e && ((m_ecnt % FRAME) == FRAME - 1);
    upper = m_act_val >> (4 * d);
    if (!e) begin
      m_seg = 7'h7F;
      m_an  = 6'h3F;
    end else begin
      dark = m_act_mask[d] || (lz && d > 0 && upper == 0);
      m_seg = dark ? 7'h7F : seg_tab[upper[3:0]];
      m_an  = dark ? 6'h3F : (6'h3F & ~(6'(1) << d));
    end
    m_fd = wrap;
    if (l && wrap) begin
      m_act_val = v; m_act_mask = bm; m_pv = 0;
    end else if (l) begin
      m_pend_val = v; m_pend_mask = bm; m_pv = 1;
    end else if (wrap && m_pv) begin
      m_act_val = m_pend_val; m_act_mask = m_pend_mask; m_pv = 0;
    end
    if (e) m_ecnt++;
    @(posedge clk);
    #1;
    chk("seg", 32'(seg), 32'(m_seg));
    chk("an", 32'(an), 32'(m_an));
    chk("digit_idx", 32'(digit_idx), 32'((m_ecnt / SD) % ND));
    chk("frame_done", 32'(frame_done), 32'(m_fd));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0; load = 1'b0;
    #2;
    check_reset_outputs();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Advance with en=1 until the model sits at the requested frame offset.
  task automatic run_to(input int pos, input bit lz, input logic [5:0] bm);
    int n;
    n = 0;
    while ((m_ecnt % FRAME) != pos && n < 2 * FRAME) begin
      step(1, 0, lz, '0, bm);
      n++;
    end
    if ((m_ecnt % FRAME) != pos) chk("wait_pos", 32'(m_ecnt % FRAME), 32'(pos));
  endtask

  initial begin
    logic [23:0] rv;
    logic [5:0]  rm;
    bit          rlz;
    model_reset();
    #12;
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) step(0, 0, 0, '0, '0);

    // Scan order and decode.
    step(1, 1, 0, 24'h0123AF, 6'h00);
    for (int i = 0; i < 60; i++) step(1, 0, 0, '0, '0);

    // No tearing: second load mid-frame.
    step(1, 1, 0, 24'h111111, 6'h00);
    run_to(FRAME / 2, 0, '0);
    step(1, 1, 0, 24'h222222, 6'h00);
    for (int i = 0; i < 40; i++) step(1, 0, 0, '0, '0);

    // Load exactly on the wrap tick.
    run_to(FRAME - 1, 0, '0);
    step(1, 1, 0, 24'hFFFFFF, 6'h00);
    for (int i = 0; i < 30; i++) step(1, 0, 0, '0, '0);

    // Leading-zero blanking, then forced mask on digit 0.
    step(1, 1, 1, 24'h000050, 6'h00);
    for (int i = 0; i < 50; i++) step(1, 0, 1, '0, '0);
    step(1, 1, 1, 24'h000050, 6'h01);
    for (int i = 0; i < 50; i++) step(1, 0, 1, '0, '0);

    // Freeze mid-digit at digit 3, then resume.
    run_to(3 * SD + 1, 1, '0);
    for (int i = 0; i < 10; i++) step(0, 0, 1, '0, '0);
    for (int i = 0; i < 30; i++) step(1, 0, 1, '0, '0);

    do_reset();

    for (int i = 0; i < 2500; i++) begin
      if (i % 100 == 0) rlz = bit'($urandom % 2);
      rv = 24'($urandom) & (24'hFFFFFF >> (4 * ($urandom % 6)));
      rm = ($urandom % 4 == 0) ? 6'($urandom) : 6'h00;
      step(($urandom % 10) != 0, ($urandom % 8) == 0, rlz, rv, rm);
      if (i == 1234) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
